if_fetch_ctrl: RTL

//   Instruction-fetch sequencer for the IF stage. Owns the PC, drives the word address of the

---
 rtl/if_fetch_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, loads the IF/ID register,
// and handles stalls, redirects, debug halt/step and perf counters.
module if_fetch_ctrl #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              dbg_halt,
   input  logic              dbg_step,
   output logic              ifid_valid,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc,
   output logic [ADDR_W+1:0] ifid_pc4,
   output logic              halted,
   output logic [CNT_W-1:0]  fetch_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2,
      STEP = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_nx;
   logic              do_fetch;
   logic              do_bubble;
   logic              fcnt_max;
   logic              bcnt_max;

   assign rom_addr = pc;
   assign halted   = (state == HALT);
   assign ifid_pc4 = {ifid_pc + ADDR_W'(1), 2'b00};
   assign fcnt_max = &fetch_cnt;
   assign bcnt_max = &bubble_cnt;

   // Redirect beats stall; stall freezes everything including the FSM.
   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      do_fetch  = 1'b0;
      do_bubble = 1'b0;
      if (redirect_valid) begin
         pc_nx     = redirect_pc;
         do_bubble = 1'b1;
      end else if (!stall) begin
         unique case (state)
            BOOT: begin
               state_nx = dbg_halt ? HALT : RUN;
            end
            RUN: begin
               if (dbg_halt) begin
                  do_bubble = 1'b1;
                  state_nx  = HALT;
               end else begin
                  do_fetch = 1'b1;
               end
            end
            HALT: begin
               do_bubble = 1'b1;
               if (dbg_step) begin
                  state_nx = STEP;
               end else if (!dbg_halt) begin
                  state_nx = RUN;
               end
            end
            STEP: begin
               do_fetch = 1'b1;
               state_nx = HALT;
            end
            default: begin
               state_nx = BOOT;
            end
         endcase
         if (do_fetch) begin
            pc_nx = pc + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
         pc    <= RST_PC;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
      end
   end

   // Invalid entries always carry a zero (nop) instruction word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc    <= '0;
      end else if (do_fetch) begin
         ifid_valid <= 1'b1;
         ifid_instr <= rom_data;
         ifid_pc    <= pc;
      end else if (do_bubble) begin
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (do_fetch && !fcnt_max) begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
         end
         if (do_bubble && !bcnt_max) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
      end
   end

endmodule
